// File: rtl/busy_qualifier.sv
// rtl/busy_qualifier.sv - busy level qualifier with rise/fall hysteresis, glitch counting and stuck detection
//
// Purpose: consumes a busy level that is already synchronous to clk and filters it.
// busy_out asserts only after ON_CYCLES consecutive high samples and deasserts only
// after OFF_CYCLES consecutive low samples. Aborted qualifications are counted as
// glitches. A busy_out that stays high for TIMEOUT_CYCLES cycles raises a sticky
// stuck flag. Setting TIMEOUT_CYCLES to 0 disables stuck detection.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   busy_in    in   raw busy level, synchronous to clk
//   stuck_clr  in   single-cycle clear of stuck
//   busy_out   out  qualified busy, registered
//   busy_rise  out  one-cycle pulse when busy_out goes 0->1
//   glitch     out  one-cycle pulse when a rise or fall qualification aborts
//   glitch_cnt out  saturating count of aborted qualifications (GCW bits)
//   stuck      out  sticky flag, busy_out held >= TIMEOUT_CYCLES

module busy_qualifier #(
    parameter int ON_CYCLES      = 4,
    parameter int OFF_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GCW            = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           busy_in,
    input  logic           stuck_clr,
    output logic           busy_out,
    output logic           busy_rise,
    output logic           glitch,
    output logic [GCW-1:0] glitch_cnt,
    output logic           stuck
);

    localparam int MAXQ = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int QW   = $clog2(MAXQ + 1);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_param
        $error("busy_qualifier: ON_CYCLES and OFF_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RISE_CHK,
        BUSY,
        FALL_CHK
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic          abort;
    logic          busy_n;
    logic          rise_n;

    always_comb begin
        state_n = state;
        qcnt_n  = qcnt;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (busy_in) begin
                    qcnt_n  = QW'(1);
                    state_n = (ON_CYCLES == 1) ? BUSY : RISE_CHK;
                end
            end
            RISE_CHK: begin
                if (busy_in) begin
                    qcnt_n = qcnt + QW'(1);
                    if (qcnt + QW'(1) == QW'(ON_CYCLES)) begin
                        state_n = BUSY;
                    end
                end else begin
                    qcnt_n  = '0;
                    state_n = IDLE;
                    abort   = 1'b1;
                end
            end
            BUSY: begin
                if (!busy_in) begin
                    qcnt_n  = QW'(1);
                    state_n = (OFF_CYCLES == 1) ? IDLE : FALL_CHK;
                end
            end
            FALL_CHK: begin
                if (!busy_in) begin
                    qcnt_n = qcnt + QW'(1);
                    if (qcnt + QW'(1) == QW'(OFF_CYCLES)) begin
                        state_n = IDLE;
                    end
                end else begin
                    qcnt_n  = '0;
                    state_n = BUSY;
                    abort   = 1'b1;
                end
            end
            default: begin
                qcnt_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    // busy_out is registered from the next state so it lines up with the state register.
    assign busy_n = (state_n == BUSY) || (state_n == FALL_CHK);
    assign rise_n = busy_n && !busy_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            qcnt       <= '0;
            busy_out   <= 1'b0;
            busy_rise  <= 1'b0;
            glitch     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state     <= state_n;
            qcnt      <= qcnt_n;
            busy_out  <= busy_n;
            busy_rise <= rise_n;
            glitch    <= abort;
            if (abort && (glitch_cnt != {GCW{1'b1}})) begin
                glitch_cnt <= glitch_cnt + GCW'(1);
            end
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

        logic [TW-1:0] tcnt;
        logic          hit;

        // Saturation at TIMEOUT_CYCLES means hit fires once per busy run, so a
        // cleared stuck stays clear until busy_out falls and a new run completes.
        assign hit = busy_out && (tcnt == TW'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tcnt  <= '0;
                stuck <= 1'b0;
            end else begin
                if (!busy_out) begin
                    tcnt <= '0;
                end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
                    tcnt <= tcnt + TW'(1);
                end
                if (hit) begin
                    stuck <= 1'b1;
                end else if (stuck_clr) begin
                    stuck <= 1'b0;
                end
            end
        end
    end else begin : g_no_timeout
        logic unused_clr;
        assign unused_clr = stuck_clr;
        assign stuck      = 1'b0;
    end

endmodule

// File: doc/busy_qualifier.md
Name: busy_qualifier

Overview:
- Receive-side companion to the busy pulse extender: consumes a busy level from a remote or stretched source.
- Filters glitches with rise/fall hysteresis and produces a clean, registered qualified busy.
- Flags busy that stays asserted longer than a configurable limit (stuck detection).
- Sits at the consumer end of the busy interface, in front of stall/arbitration logic.

Parameters:
ON_CYCLES, 4, consecutive high samples of busy_in required before busy_out asserts (>=1)
OFF_CYCLES, 4, consecutive low samples of busy_in required before busy_out deasserts (>=1)
TIMEOUT_CYCLES, 1024, cycles of continuous busy_out=1 before stuck is flagged; 0 disables detection
GCW, 8, width of saturating glitch counter

Ports:
clk  input  1  clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
busy_in  input  1  raw busy level, already synchronous to clk (no synchronizer inside)
stuck_clr  input  1  single-cycle clear of stuck flag
busy_out  output  1  qualified busy, registered
busy_rise  output  1  one-cycle pulse on the cycle busy_out goes 0->1
glitch  output  1  one-cycle pulse when a rise or fall qualification aborts
glitch_cnt  output  GCW  saturating count of aborted qualifications
stuck  output  1  sticky flag, busy_out held >= TIMEOUT_CYCLES

Behaviour:
- Reset (reset_n=0, async): state=IDLE; counters=0; busy_out=0, busy_rise=0, glitch=0, glitch_cnt=0, stuck=0. Reset mid-qualification discards all progress.
- FSM states: IDLE, RISE_CHK, BUSY, FALL_CHK. busy_out=1 in BUSY and FALL_CHK only, and is driven from a register.
- IDLE:
  - busy_in=1 -> qual counter=1.
  - If ON_CYCLES==1, go straight to BUSY; otherwise go to RISE_CHK.
- RISE_CHK:
  - busy_in=1 -> counter++. When the counter reaches ON_CYCLES, go to BUSY.
  - busy_in=0 -> IDLE; pulse glitch; glitch_cnt+1, saturating at all-ones.
- Rise latency: busy_in sampled high on edges k..k+ON_CYCLES-1 means busy_out=1 and busy_rise=1 after edge k+ON_CYCLES-1. busy_rise is high for exactly one cycle.
- BUSY:
  - busy_in=0 -> qual counter=1.
  - If OFF_CYCLES==1, go to IDLE; otherwise go to FALL_CHK.
- FALL_CHK:
  - busy_in=0 -> counter++. When the counter reaches OFF_CYCLES, go to IDLE; busy_out=0 after that edge.
  - busy_in=1 -> back to BUSY; pulse glitch; glitch_cnt+1, saturating.
- Timeout counter:
  - Counts every cycle busy_out=1, including FALL_CHK. Resets to 0 in IDLE/RISE_CHK. Saturates at TIMEOUT_CYCLES.
  - Sets stuck on the edge the count reaches TIMEOUT_CYCLES. stuck has no effect on the FSM.
- stuck clearing:
  - stuck is cleared only by stuck_clr or reset.
  - If stuck_clr and the set condition occur in the same cycle, set wins.
  - After a clear, stuck does not re-set until busy_out falls and a fresh TIMEOUT_CYCLES run completes.
- TIMEOUT_CYCLES==0: stuck is held 0; the timeout counter may be optimised away.
- Widths: qual counter is clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits; timeout counter is clog2(TIMEOUT_CYCLES+1) bits.
- Out-of-range parameters (ON/OFF_CYCLES < 1) are an elaboration-time error.

Test Plan:
- Reset, then busy_in held high 10 cycles (ON=4) -> busy_out rises after 4th high-sample edge; busy_rise pulses once; glitch_cnt=0.
- busy_in high 3 cycles, low 1, repeated 5 times -> busy_out stays 0; glitch pulses 5 times; glitch_cnt=5.
- In BUSY: busy_in low 3, high 1, low 4 (OFF=4) -> one glitch; busy_out drops only after the 4th consecutive low edge.
- TIMEOUT_CYCLES=16, busy_in high 40 cycles -> stuck=1 exactly 16 cycles after busy_out rose. stuck_clr at cycle 30 -> stuck=0 and stays 0. Drop busy_in, then re-hold -> stuck sets again after 16.
- GCW=3, 9 aborted rises -> glitch_cnt saturates at 7.
- reset_n pulsed low mid-FALL_CHK with stuck=1 -> all outputs 0 immediately (async). After release, busy_in high needs a full ON_CYCLES re-qualification.
